// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_pkg
//  Description : Shared definitions for the sequential ALU.
//                - Op-code constants OP_AND .. OP_DIV
//                - FSM state encoding ST_IDLE / ST_ITER
//                - iter_cnt_w(): width of the iteration counter
//  Revision    : 1.0  initial release
// ============================================================================
package seq_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ITER = 1'b1;

  // The counter runs 0 .. width-1, so clog2(width) bits are enough.
  function automatic int iter_cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_comb.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_comb
//  Description : Purely combinational single-cycle datapath of the ALU
//                (AND, OR, ADD, SUB, SLT, SLL) with carry/overflow/zero.
//                MUL/DIV codes yield r = 0 here; they are handled by the
//                iterative engine in seq_alu.
//  Ports       : op     - operation code
//                a, b   - operands
//                r      - result
//                c_out  - carry (ADD) / no-borrow (SUB), else 0
//                ovfl   - signed overflow (ADD/SUB), else 0
//                zero   - r == 0
//  Revision    : 1.0  initial release
// ============================================================================
module seq_alu_comb
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             c_out,
  output logic             ovfl,
  output logic             zero
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    // a - b as a + ~b + 1: the carry out is the no-borrow indication.
    diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    r     = '0;
    c_out = 1'b0;
    ovfl  = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: begin
        r     = sum[WIDTH-1:0];
        c_out = sum[WIDTH];
        ovfl  = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r     = diff[WIDTH-1:0];
        c_out = diff[WIDTH];
        ovfl  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: r = a << b[SHAMT_W-1:0];
      default: r = '0;
    endcase
    zero = (r == '0);
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Registered ALU. Single-cycle ops complete one cycle after
//                start; MUL (and DIV when SEQ_ALU_DIV_EN is defined) iterate
//                one bit per cycle for WIDTH cycles. Without SEQ_ALU_DIV_EN
//                op 111 is illegal and no divider logic exists.
//  Ports       : clk, reset (sync, active high)
//                start, op, A, B   - request and operands
//                busy              - iterative op in progress
//                done              - one-cycle result-valid pulse
//                R, R_hi           - result / high half or remainder
//                c_out, ovfl, zero, err - flags, valid with done
//  Revision    : 1.0  initial release
// ============================================================================
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] R_hi,
  output logic             c_out,
  output logic             ovfl,
  output logic             zero,
  output logic             err
);

  localparam int               CNT_W    = iter_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // MUL high half / DIV remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // MUL multiplier->low half / DIV dividend->quotient
  logic [WIDTH-1:0] opd_q, opd_d;     // MUL multiplicand / DIV divisor
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             c_out_q, c_out_d;
  logic             ovfl_q, ovfl_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] comb_r;
  logic             comb_c_out;
  logic             comb_ovfl;
  logic             comb_zero;

  seq_alu_comb #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_comb (
    .op    (op),
    .a     (A),
    .b     (B),
    .r     (comb_r),
    .c_out (comb_c_out),
    .ovfl  (comb_ovfl),
    .zero  (comb_zero)
  );

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole {carry,acc,lo} right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_nx;
  logic [WIDTH-1:0] mul_lo_nx;

  always_comb begin
    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
    mul_acc_nx = mul_sum[WIDTH:1];
    mul_lo_nx  = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  logic iter_div;   // the op starting now is a divide
  logic illegal;    // the op starting now is op 111 with no divider

`ifdef SEQ_ALU_DIV_EN
  // Restoring divide step: shift next dividend bit into the remainder and
  // subtract the divisor. A non-negative trial keeps the difference and
  // shifts a 1 into the quotient. Since the remainder stays below the
  // divisor, bit WIDTH of the trial is a reliable sign bit; with a zero
  // divisor every trial succeeds, giving all-ones quotient and remainder A.
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_rem_nx;
  logic [WIDTH-1:0] div_quo_nx;

  always_comb begin
    div_trial = {acc_q, lo_q[WIDTH-1]} - {1'b0, opd_q};
    if (!div_trial[WIDTH]) begin
      div_rem_nx = div_trial[WIDTH-1:0];
      div_quo_nx = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_nx = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
      div_quo_nx = {lo_q[WIDTH-2:0], 1'b0};
    end
    iter_div = (op == OP_DIV);
    illegal  = 1'b0;
  end
`else
  always_comb begin
    iter_div = 1'b0;
    illegal  = (op == OP_DIV);
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opd_d    = opd_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    c_out_d  = c_out_q;
    ovfl_d   = ovfl_q;
    zero_d   = zero_q;
    err_d    = err_q;
    done_d   = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    is_div_d = is_div_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((op == OP_MUL) || iter_div) begin
            state_d = ST_ITER;
            cnt_d   = '0;
            acc_d   = '0;
            lo_d    = iter_div ? A : B;
            opd_d   = iter_div ? B : A;
`ifdef SEQ_ALU_DIV_EN
            is_div_d = iter_div;
`endif
          end else begin
            res_d    = comb_r;
            res_hi_d = '0;
            c_out_d  = comb_c_out;
            ovfl_d   = comb_ovfl;
            zero_d   = comb_zero & ~illegal;
            err_d    = illegal;
            done_d   = 1'b1;
          end
        end
      end
      ST_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_ALU_DIV_EN
        if (is_div_q) begin
          acc_d = div_rem_nx;
          lo_d  = div_quo_nx;
        end else begin
          acc_d = mul_acc_nx;
          lo_d  = mul_lo_nx;
        end
`else
        acc_d = mul_acc_nx;
        lo_d  = mul_lo_nx;
`endif
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_IDLE;
          res_d    = lo_d;
          res_hi_d = acc_d;
          c_out_d  = 1'b0;
          ovfl_d   = 1'b0;
          done_d   = 1'b1;
`ifdef SEQ_ALU_DIV_EN
          zero_d = is_div_q ? (lo_d == '0) : ({acc_d, lo_d} == '0);
          err_d  = is_div_q && (opd_q == '0);
`else
          zero_d = ({acc_d, lo_d} == '0);
          err_d  = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opd_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      c_out_q  <= 1'b0;
      ovfl_q   <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opd_q    <= opd_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      c_out_q  <= c_out_d;
      ovfl_q   <= ovfl_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      done_q   <= done_d;
`ifdef SEQ_ALU_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  assign busy  = (state_q == ST_ITER);
  assign done  = done_q;
  assign R     = res_q;
  assign R_hi  = res_hi_q;
  assign c_out = c_out_q;
  assign ovfl  = ovfl_q;
  assign zero  = zero_q;
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed testbench for seq_alu (WIDTH = 16). Expected values
//                are hand-computed. Honours SEQ_ALU_DIV_EN for op 111.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy, done, c_out, ovfl, zero, err;
  logic [15:0] R, R_hi;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .R     (R),
    .R_hi  (R_hi),
    .c_out (c_out),
    .ovfl  (ovfl),
    .zero  (zero),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns 1 ns after that edge.
  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    op = o; A = a; B = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Edges until done rises, -1 if it never does within the bound.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  // flags vector order: {busy, done, err, c_out, ovfl, zero}
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, done, err, c_out, ovfl, zero} !== 6'b000000 || R !== 16'h0000 || R_hi !== 16'h0000) begin
      errors++;
      $display("FAIL reset: flags=%b R=%h R_hi=%h, want flags=000000 R=0000 R_hi=0000",
               {busy, done, err, c_out, ovfl, zero}, R, R_hi);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_add();
    issue(3'b010, 16'hFFFF, 16'hFFFF);
    checks++;
    if ({busy, done, err, c_out, ovfl, zero} !== 6'b010100 || R !== 16'hFFFE || R_hi !== 16'h0000) begin
      errors++;
      $display("FAIL add_ffff: flags=%b R=%h R_hi=%h, want flags=010100 R=fffe R_hi=0000",
               {busy, done, err, c_out, ovfl, zero}, R, R_hi);
    end
    step();
    checks++;
    if (done !== 1'b0 || R !== 16'hFFFE) begin
      errors++;
      $display("FAIL add_hold: done=%b R=%h, want done=0 R=fffe", done, R);
    end
    issue(3'b010, 16'h7FFF, 16'h0001);
    checks++;
    if ({done, err, c_out, ovfl, zero} !== 5'b10010 || R !== 16'h8000) begin
      errors++;
      $display("FAIL add_ovfl: flags=%b R=%h, want flags=10010 R=8000",
               {done, err, c_out, ovfl, zero}, R);
    end
    step();
  endtask

  task automatic test_sub();
    issue(3'b011, 16'h8000, 16'h0001);
    checks++;
    if ({done, err, c_out, ovfl, zero} !== 5'b10110 || R !== 16'h7FFF) begin
      errors++;
      $display("FAIL sub_ovfl: flags=%b R=%h, want flags=10110 R=7fff",
               {done, err, c_out, ovfl, zero}, R);
    end
    step();
    issue(3'b011, 16'h0005, 16'h0005);
    checks++;
    if ({done, err, c_out, ovfl, zero} !== 5'b10101 || R !== 16'h0000) begin
      errors++;
      $display("FAIL sub_zero: flags=%b R=%h, want flags=10101 R=0000",
               {done, err, c_out, ovfl, zero}, R);
    end
    step();
  endtask

  task automatic test_logic_shift();
    issue(3'b000, 16'hF0F0, 16'hFF00);
    checks++;
    if (R !== 16'hF000 || {done, c_out, ovfl, zero} !== 4'b1000) begin
      errors++;
      $display("FAIL and: R=%h flags=%b, want R=f000 flags=1000", R, {done, c_out, ovfl, zero});
    end
    issue(3'b001, 16'hF0F0, 16'hFF00);
    checks++;
    if (R !== 16'hFFF0 || done !== 1'b1) begin
      errors++;
      $display("FAIL or: R=%h done=%b, want R=fff0 done=1", R, done);
    end
    issue(3'b100, 16'h8000, 16'h0001);
    checks++;
    if (R !== 16'h0001 || zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_true: R=%h zero=%b, want R=0001 zero=0", R, zero);
    end
    issue(3'b100, 16'h0001, 16'h8000);
    checks++;
    if (R !== 16'h0000 || zero !== 1'b1) begin
      errors++;
      $display("FAIL slt_false: R=%h zero=%b, want R=0000 zero=1", R, zero);
    end
    // Shift amount 0x14 truncates to 4.
    issue(3'b101, 16'h0001, 16'h0014);
    checks++;
    if (R !== 16'h0010 || R_hi !== 16'h0000 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL sll_trunc: R=%h R_hi=%h c_out=%b, want R=0010 R_hi=0000 c_out=0", R, R_hi, c_out);
    end
    step();
  endtask

  task automatic test_mul();
    int n;
    int busy_cycles;
    issue(3'b110, 16'hFFFF, 16'hFFFF);
    busy_cycles = 0;
    n = -1;
    for (int i = 0; i <= 40; i++) begin
      if (done) begin
        n = i;
        break;
      end
      if (busy) busy_cycles++;
      step();
    end
    checks++;
    if (n !== 16 || busy_cycles !== 16) begin
      errors++;
      $display("FAIL mul_latency: done_after=%0d busy_cycles=%0d, want 16 and 16", n, busy_cycles);
    end
    checks++;
    if (R !== 16'h0001 || R_hi !== 16'hFFFE || {busy, err, c_out, ovfl, zero} !== 5'b00000) begin
      errors++;
      $display("FAIL mul_ffff: R=%h R_hi=%h flags=%b, want R=0001 R_hi=fffe flags=00000",
               R, R_hi, {busy, err, c_out, ovfl, zero});
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mul_pulse: done=%b, want 0", done);
    end
    issue(3'b110, 16'h00FF, 16'h0101);
    wait_done(n);
    checks++;
    if (n !== 16 || R !== 16'hFFFF || R_hi !== 16'h0000) begin
      errors++;
      $display("FAIL mul_00ff: n=%0d R=%h R_hi=%h, want n=16 R=ffff R_hi=0000", n, R, R_hi);
    end
    step();
  endtask

  task automatic test_mul_ignore_start();
    int n;
    issue(3'b110, 16'hFFFF, 16'hFFFF);
    repeat (4) step();
    issue(3'b010, 16'h0001, 16'h0001);
    wait_done(n);
    checks++;
    if (n !== 11 || R !== 16'h0001 || R_hi !== 16'hFFFE) begin
      errors++;
      $display("FAIL mul_ignore: n=%0d R=%h R_hi=%h, want n=11 R=0001 R_hi=fffe", n, R, R_hi);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_ignore_single: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    issue(3'b110, 16'h1234, 16'h5678);
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({busy, done, err} !== 3'b000 || R !== 16'h0000 || R_hi !== 16'h0000) begin
      errors++;
      $display("FAIL abort: busy/done/err=%b R=%h R_hi=%h, want 000 0000 0000", {busy, done, err}, R, R_hi);
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      step();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d, want 0", dones);
    end
    issue(3'b010, 16'h0002, 16'h0003);
    checks++;
    if (done !== 1'b1 || R !== 16'h0005) begin
      errors++;
      $display("FAIL abort_add: done=%b R=%h, want done=1 R=0005", done, R);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'b010, 16'h0010, 16'h0020);
    checks++;
    if (done !== 1'b1 || R !== 16'h0030) begin
      errors++;
      $display("FAIL b2b_first: done=%b R=%h, want done=1 R=0030", done, R);
    end
    issue(3'b011, 16'h0010, 16'h0020);
    checks++;
    if (done !== 1'b1 || R !== 16'hFFF0 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: done=%b R=%h c_out=%b, want done=1 R=fff0 c_out=0", done, R, c_out);
    end
    issue(3'b110, 16'h0003, 16'h0004);
    wait_done(n);
    checks++;
    if (n !== 16 || R !== 16'h000C) begin
      errors++;
      $display("FAIL b2b_mul1: n=%0d R=%h, want n=16 R=000c", n, R);
    end
    issue(3'b110, 16'h00FF, 16'h0101);
    wait_done(n);
    checks++;
    if (n !== 16 || R !== 16'hFFFF || R_hi !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_mul2: n=%0d R=%h R_hi=%h, want n=16 R=ffff R_hi=0000", n, R, R_hi);
    end
    step();
  endtask

  task automatic test_op111();
`ifdef SEQ_ALU_DIV_EN
    int n;
    issue(3'b111, 16'h0064, 16'h0007);
    wait_done(n);
    checks++;
    if (n !== 16 || R !== 16'h000E || R_hi !== 16'h0002 || err !== 1'b0) begin
      errors++;
      $display("FAIL div: n=%0d R=%h R_hi=%h err=%b, want n=16 R=000e R_hi=0002 err=0", n, R, R_hi, err);
    end
    step();
    issue(3'b111, 16'h0064, 16'h0000);
    wait_done(n);
    checks++;
    if (n !== 16 || R !== 16'hFFFF || R_hi !== 16'h0064 || err !== 1'b1) begin
      errors++;
      $display("FAIL div_by0: n=%0d R=%h R_hi=%h err=%b, want n=16 R=ffff R_hi=0064 err=1", n, R, R_hi, err);
    end
    step();
`else
    issue(3'b111, 16'h1234, 16'h5678);
    checks++;
    if ({busy, done, err, c_out, ovfl, zero} !== 6'b011000 || R !== 16'h0000 || R_hi !== 16'h0000) begin
      errors++;
      $display("FAIL illegal: flags=%b R=%h R_hi=%h, want flags=011000 R=0000 R_hi=0000",
               {busy, done, err, c_out, ovfl, zero}, R, R_hi);
    end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_mul();
    test_mul_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_op111();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
